data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 130 +++++++++++++
 tb/tb_data_memory.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Block-wide backing memory behind the cache controller: 64 blocks x 32 bits.
//   Each accepted read or write spends LATENCY cycles in BUSY, performs the
//   access on the last BUSY edge, then spends one cycle in DONE with busywait
//   low before returning to IDLE.
//
// Parameters
//   LATENCY    number of BUSY cycles per access (1..15)
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-high; aborts any access in flight
//   read       block read request
//   write      block write request (wins over read when both are high)
//   address    block address {tag, index}
//   writedata  block to write, byte k in bits [8k+7:8k]
//   readdata   registered result of the most recent completed read
//   busywait   high while a request has not yet completed
//
// Configuration
//   DMEM_INIT_PATTERN_EN  defined: reset loads block i with bytes
//                         {4i+3, 4i+2, 4i+1, 4i}; undefined: reset loads zeros
// -----------------------------------------------------------------------------
module data_memory #(
   parameter int unsigned LATENCY = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [5:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        busywait
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t      state;
   state_t      next_state;
   logic [3:0]  cnt;
   logic [5:0]  addr_q;
   logic [31:0] data_q;
   logic        write_q;
   logic [31:0] mem [0:63];

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; busywait has a combinational request term so the
   // requester sees it in its very first request cycle.
   always_comb begin
      next_state = state;
      busywait   = 1'b0;
      unique case (state)
         IDLE: begin
            if (read || write) begin
               next_state = BUSY;
               busywait   = 1'b1;
            end
         end
         BUSY: begin
            busywait = 1'b1;
            if (cnt == 4'd0) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (reset) begin
         busywait = 1'b0;
      end
   end

   // Request capture, latency counter, storage and read register
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt      <= '0;
         readdata <= '0;
         for (int unsigned i = 0; i < 64; i++) begin
`ifdef DMEM_INIT_PATTERN_EN
            mem[i] <= {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
`else
            mem[i] <= '0;
`endif
         end
      end else begin
         case (state)
            IDLE: begin
               if (read || write) begin
                  addr_q  <= address;
                  data_q  <= writedata;
                  write_q <= write;
                  cnt     <= CNT_LOAD;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (write_q) begin
                  mem[addr_q] <= data_q;
               end else begin
                  readdata <= mem[addr_q];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//   Directed self-checking bench for data_memory. One instance uses the
//   default LATENCY=4, a second uses LATENCY=1; both share clock and reset.
//   Expected reset contents follow DMEM_INIT_PATTERN_EN.
// -----------------------------------------------------------------------------
module tb_data_memory;

   logic        clock;
   logic        reset;

   logic        read;
   logic        write;
   logic [5:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        busywait;

   logic        l1_read;
   logic        l1_write;
   logic [5:0]  l1_address;
   logic [31:0] l1_writedata;
   logic [31:0] l1_readdata;
   logic        l1_busywait;

   int n_checks;
   int n_fail;

   data_memory #(.LATENCY(4)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .read      (read),
      .write     (write),
      .address   (address),
      .writedata (writedata),
      .readdata  (readdata),
      .busywait  (busywait)
   );

   data_memory #(.LATENCY(1)) u_lat1 (
      .clock     (clock),
      .reset     (reset),
      .read      (l1_read),
      .write     (l1_write),
      .address   (l1_address),
      .writedata (l1_writedata),
      .readdata  (l1_readdata),
      .busywait  (l1_busywait)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] reset_word(input int unsigned i);
`ifdef DMEM_INIT_PATTERN_EN
      return {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
`else
      return (i > 64) ? 32'hFFFF_FFFF : 32'h0;
`endif
   endfunction

   // One request held until busywait falls; ends in the DONE cycle with the
   // request dropped. busy counts cycles sampled with busywait high.
   task automatic access(input bit sel, input logic wr, input logic rd,
                         input logic [5:0] a, input logic [31:0] d,
                         output int busy);
      busy = 0;
      @(negedge clock);
      if (sel) begin
         l1_write = wr; l1_read = rd; l1_address = a; l1_writedata = d;
      end else begin
         write = wr; read = rd; address = a; writedata = d;
      end
      #1;
      while ((sel ? l1_busywait : busywait) && busy < 64) begin
         busy++;
         @(negedge clock);
         #1;
      end
      if (sel) begin
         l1_write = 1'b0; l1_read = 1'b0;
      end else begin
         write = 1'b0; read = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      read = 1'b1;
      #1;
      n_checks++;
      if (busywait !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busywait: got %b expected 0", busywait);
      end
      read = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_readdata: got %h expected 00000000", readdata);
      end
      n_checks++;
      if (l1_readdata !== 32'h0 || l1_busywait !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_lat1: got rd=%h bw=%b expected 00000000/0", l1_readdata, l1_busywait);
      end
   endtask

   task automatic test_read();
      int busy;
      access(1'b0, 1'b0, 1'b1, 6'd5, 32'h0, busy);
      n_checks++;
      if (busy !== 5) begin
         n_fail++;
         $display("FAIL read5_busy: got %0d expected 5", busy);
      end
      n_checks++;
      if (readdata !== reset_word(5)) begin
         n_fail++;
         $display("FAIL read5_data: got %h expected %h", readdata, reset_word(5));
      end
      @(negedge clock);
      #1;
      n_checks++;
      if (busywait !== 1'b0 || readdata !== reset_word(5)) begin
         n_fail++;
         $display("FAIL read5_hold: got bw=%b rd=%h expected 0/%h", busywait, readdata, reset_word(5));
      end
   endtask

   task automatic test_back_to_back();
      int busy;
      access(1'b0, 1'b1, 1'b0, 6'h2A, 32'hDEADBEEF, busy);
      n_checks++;
      if (busy !== 5) begin
         n_fail++;
         $display("FAIL b2b_write_busy: got %0d expected 5", busy);
      end
      n_checks++;
      if (readdata !== reset_word(5)) begin
         n_fail++;
         $display("FAIL b2b_write_keeps_readdata: got %h expected %h", readdata, reset_word(5));
      end
      access(1'b0, 1'b0, 1'b1, 6'h2A, 32'h0, busy);
      n_checks++;
      if (busy !== 5) begin
         n_fail++;
         $display("FAIL b2b_read_busy: got %0d expected 5", busy);
      end
      n_checks++;
      if (readdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL b2b_read_data: got %h expected deadbeef", readdata);
      end
   endtask

   task automatic test_priority();
      int busy;
      access(1'b0, 1'b1, 1'b1, 6'd3, 32'h11223344, busy);
      n_checks++;
      if (busy !== 5 || readdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL prio_as_write: got busy=%0d rd=%h expected 5/deadbeef", busy, readdata);
      end
      access(1'b0, 1'b0, 1'b1, 6'd3, 32'h0, busy);
      n_checks++;
      if (readdata !== 32'h11223344) begin
         n_fail++;
         $display("FAIL prio_readback: got %h expected 11223344", readdata);
      end
   endtask

   task automatic test_withdraw();
      int busy;
      access(1'b0, 1'b1, 1'b0, 6'd10, 32'hA5A5A5A5, busy);
      busy = 0;
      @(negedge clock);
      read = 1'b1;
      address = 6'd9;
      #1;
      if (busywait) busy++;
      @(negedge clock);
      read = 1'b0;
      address = 6'd10;
      #1;
      while (busywait && busy < 64) begin
         busy++;
         @(negedge clock);
         #1;
      end
      n_checks++;
      if (busy !== 5) begin
         n_fail++;
         $display("FAIL withdraw_busy: got %0d expected 5", busy);
      end
      n_checks++;
      if (readdata !== reset_word(9)) begin
         n_fail++;
         $display("FAIL withdraw_data: got %h expected %h", readdata, reset_word(9));
      end
   endtask

   task automatic test_reset_during_busy();
      int busy;
      access(1'b0, 1'b0, 1'b1, 6'h2A, 32'h0, busy);
      @(negedge clock);
      write = 1'b1;
      address = 6'd1;
      writedata = 32'hCAFEF00D;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      write = 1'b0;
      #1;
      n_checks++;
      if (busywait !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busywait: got %b expected 0", busywait);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'h0 || busywait !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_readdata: got rd=%h bw=%b expected 00000000/0", readdata, busywait);
      end
      access(1'b0, 1'b0, 1'b1, 6'd1, 32'h0, busy);
      n_checks++;
      if (busy !== 5 || readdata !== reset_word(1)) begin
         n_fail++;
         $display("FAIL abort_block1: got busy=%0d rd=%h expected 5/%h", busy, readdata, reset_word(1));
      end
      access(1'b0, 1'b0, 1'b1, 6'h2A, 32'h0, busy);
      n_checks++;
      if (readdata !== reset_word(42)) begin
         n_fail++;
         $display("FAIL abort_reinit_2a: got %h expected %h", readdata, reset_word(42));
      end
   endtask

   task automatic test_latency1();
      int busy;
      access(1'b1, 1'b1, 1'b0, 6'd62, 32'h5A5AC3C3, busy);
      n_checks++;
      if (busy !== 2) begin
         n_fail++;
         $display("FAIL lat1_write_busy: got %0d expected 2", busy);
      end
      access(1'b1, 1'b0, 1'b1, 6'd62, 32'h0, busy);
      n_checks++;
      if (busy !== 2 || l1_readdata !== 32'h5A5AC3C3) begin
         n_fail++;
         $display("FAIL lat1_read62: got busy=%0d rd=%h expected 2/5a5ac3c3", busy, l1_readdata);
      end
      access(1'b1, 1'b0, 1'b1, 6'd63, 32'h0, busy);
      n_checks++;
      if (busy !== 2) begin
         n_fail++;
         $display("FAIL lat1_read63_busy: got %0d expected 2", busy);
      end
      n_checks++;
      if (l1_readdata !== reset_word(63)) begin
         n_fail++;
         $display("FAIL lat1_read63_data: got %h expected %h", l1_readdata, reset_word(63));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      reset = 1'b1;
      read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      l1_read = 1'b0; l1_write = 1'b0; l1_address = '0; l1_writedata = '0;
      repeat (2) @(posedge clock);
      test_reset();
      test_read();
      test_back_to_back();
      test_priority();
      test_withdraw();
      test_reset_during_busy();
      test_latency1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
